// File: rtl/chebyshev_pkg.sv
// Shared types and fixed-point constants for the Chebyshev recurrence block.
// Defaults correspond to WL=12, I_BITS=6 (Q6.6); modules derive their own
// fraction width from their parameters through frac_bits().
package chebyshev_pkg;

  localparam int WL_DEF     = 12;
  localparam int I_BITS_DEF = 6;
  localparam int ORD_W_DEF  = 4;

  localparam int F = WL_DEF - I_BITS_DEF;
  localparam logic [WL_DEF-1:0] ONE = WL_DEF'(1) << F;
  localparam int PROD_W = 2 * WL_DEF + 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  function automatic int frac_bits(input int wl, input int i_bits);
    return wl - i_bits;
  endfunction

endpackage

// File: rtl/chebyshev_mac.sv
// Combinational recurrence step: y = wrap((2*a*b) >>> F) - c, wrapped to WL bits.
// ovf flags a shifted product or a difference that does not fit WL signed bits.
import chebyshev_pkg::*;

module chebyshev_mac #(
  parameter int WL     = WL_DEF,
  parameter int I_BITS = I_BITS_DEF
) (
  input  logic signed [WL-1:0] a,
  input  logic signed [WL-1:0] b,
  input  logic signed [WL-1:0] c,
  output logic signed [WL-1:0] y,
  output logic                 ovf
);

  localparam int FB = frac_bits(WL, I_BITS);
  localparam int PW = 2 * WL + 1;
  localparam int DW = WL + 1;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [WL-1:0] prod_w;
  logic signed [DW-1:0] diff;

  // Exact doubled product, floor shift, wrap, then wrapped subtraction.
  always_comb begin
    a_ext   = PW'(a);
    b_ext   = PW'(b);
    prod    = (a_ext * b_ext) <<< 1;
    shifted = prod >>> FB;
    prod_w  = shifted[WL-1:0];
    diff    = DW'(prod_w) - DW'(c);
    y       = diff[WL-1:0];
    ovf     = (shifted[PW-1:WL-1] != {(PW-WL+1){shifted[WL-1]}})
            | (diff[WL] ^ diff[WL-1]);
  end

endmodule

// File: rtl/chebyshev_recurrence.sv
// Iterative Chebyshev T_n(x) evaluator, one recurrence step per clock.
// Optional macro CHEBYSHEV_OVF_EN adds a sticky ovf_out flag.
// No saturation here; range reduction is done downstream.
import chebyshev_pkg::*;

module chebyshev_recurrence #(
  parameter int WL     = 12,
  parameter int I_BITS = 6,
  parameter int ORD_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WL-1:0]    x_in,
  input  logic [ORD_W-1:0] n_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WL-1:0]    t_out
`ifdef CHEBYSHEV_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int FB = frac_bits(WL, I_BITS);
  localparam logic [WL-1:0] ONE_W = WL'(1) << FB;

  state_t           state;
  logic [WL-1:0]    x_r;
  logic [ORD_W-1:0] n_r;
  logic [ORD_W-1:0] k;
  logic [WL-1:0]    t_prev;
  logic [WL-1:0]    t_cur;
  logic [WL-1:0]    mac_y;

`ifdef CHEBYSHEV_OVF_EN
  logic mac_ovf;
  logic ovf_r;
  assign ovf_out = ovf_r;
`endif

  chebyshev_mac #(
    .WL     (WL),
    .I_BITS (I_BITS)
  ) u_mac (
    .a   (x_r),
    .b   (t_cur),
    .c   (t_prev),
    .y   (mac_y),
`ifdef CHEBYSHEV_OVF_EN
    .ovf (mac_ovf)
`else
    .ovf ()
`endif
  );

  // Control FSM with registered handshake outputs and recurrence datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      t_out     <= '0;
      t_prev    <= '0;
      t_cur     <= '0;
      k         <= '0;
      x_r       <= '0;
      n_r       <= '0;
`ifdef CHEBYSHEV_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_r      <= x_in;
            n_r      <= n_in;
            t_prev   <= ONE_W;
            t_cur    <= x_in;
            k        <= ORD_W'(1);
            in_ready <= 1'b0;
            state    <= ITER;
`ifdef CHEBYSHEV_OVF_EN
            ovf_r    <= 1'b0;
`endif
          end
        end
        ITER: begin
          if (k >= n_r) begin
            // n=0 never iterates, so its result must be forced to ONE.
            t_out     <= (n_r == '0) ? ONE_W : t_cur;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            t_prev <= t_cur;
            t_cur  <= mac_y;
            k      <= k + ORD_W'(1);
`ifdef CHEBYSHEV_OVF_EN
            ovf_r  <= ovf_r | mac_ovf;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chebyshev_recurrence.sv
// Scoreboard bench for chebyshev_recurrence: driver pushes expected results,
// a negedge monitor pops and compares whenever out_valid presents a result.
module tb_chebyshev_recurrence;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] x_in = '0;
  logic [3:0]  n_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] t_out;
`ifdef CHEBYSHEV_OVF_EN
  logic        ovf_out;
`endif

  chebyshev_recurrence dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .n_in      (n_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .t_out     (t_out)
`ifdef CHEBYSHEV_OVF_EN
    ,
    .ovf_out   (ovf_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] t;
    bit          ovf;
    int          lat;
    int          acc;
    int          hold;
  } item_t;

  item_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  function automatic longint wrap12(input longint v);
    longint w;
    w = v & 64'hFFF;
    if (w >= 2048) w = w - 4096;
    return w;
  endfunction

  // T_0 = 1, T_1 = x, T_k+1 = 2 x T_k - T_k-1 in Q6.6 with floor and wrap.
  function automatic void ref_model(input logic [11:0] x, input int n,
                                    output logic [11:0] t, output bit ov);
    longint xs, tp, tc, tn, p;
    xs = longint'($signed(x));
    tp = 64;
    tc = xs;
    ov = 1'b0;
    if (n == 0) begin
      t = 12'h040;
      return;
    end
    for (int i = 1; i < n; i++) begin
      p = (2 * xs * tc) >>> 6;
      if (p > 2047 || p < -2048) ov = 1'b1;
      p  = wrap12(p);
      tn = p - tp;
      if (tn > 2047 || tn < -2048) ov = 1'b1;
      tn = wrap12(tn);
      tp = tc;
      tc = tn;
    end
    t = tc[11:0];
  endfunction

  task automatic send(input logic [11:0] x, input int n, input logic [11:0] t_exp,
                      input bit ov_exp, input int hold);
    int    guard;
    item_t it;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      return;
    end
    in_valid = 1'b1;
    x_in     = x;
    n_in     = 4'(n);
    it.t     = t_exp;
    it.ovf   = ov_exp;
    it.lat   = (n == 0) ? 1 : n;
    it.acc   = cycle + 1;
    it.hold  = hold;
    exp_q.push_back(it);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand(input int hold);
    logic [11:0] x;
    int          n;
    logic [11:0] t;
    bit          ov;
    x = 12'($urandom_range(0, 4095));
    n = $urandom_range(0, 15);
    ref_model(x, n, t, ov);
    send(x, n, t, ov, hold);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare each new result, then check it stays put while stalled.
  logic        prev_valid = 1'b0;
  int          hold_left = 0;
  logic [11:0] held_t;
  item_t       cur;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      out_ready  = 1'b0;
      hold_left  = 0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: t_out got %h expected no result", t_out);
            hold_left = 0;
          end else begin
            cur = exp_q.pop_front();
            chk("t_out", 32'(t_out), 32'(cur.t));
            chk("latency", 32'(cycle - cur.acc), 32'(cur.lat));
`ifdef CHEBYSHEV_OVF_EN
            chk("ovf_out", 32'(ovf_out), 32'(cur.ovf));
`endif
            hold_left = cur.hold;
          end
          held_t = t_out;
        end else begin
          chk("hold_t_out", 32'(t_out), 32'(held_t));
          chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = (hold_left == 0);
        if (hold_left > 0) hold_left--;
      end else begin
        out_ready = 1'b0;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_t_out", 32'(t_out), 32'd0);
    rst = 1'b0;

    send(12'h020, 2, 12'hFE0, 1'b0, 0);
    send(12'h020, 3, 12'hFC0, 1'b0, 5);
    send(12'h5A5, 0, 12'h040, 1'b0, 1);
    send(12'h7C0, 1, 12'h7C0, 1'b0, 0);
    send(12'h040, 15, 12'h040, 1'b0, 2);
    send(12'h080, 4, 12'h840, 1'b1, 0);
    send(12'h020, 2, 12'hFE0, 1'b0, 0);
    for (int i = 0; i < 40; i++) send_rand($urandom_range(0, 3));
    drain();

    // Reset in the middle of an n=10 iteration (k=4).
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 12'h123;
    n_in     = 4'd10;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_t_out", 32'(t_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(12'h020, 2, 12'hFE0, 1'b0, 0);
    for (int i = 0; i < 10; i++) send_rand(0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chebyshev_recurrence.md
CHEBYSHEV_RECURRENCE -- requirements
Module: chebyshev_recurrence

Interface
REQ-001 Parameters SHALL be one per line as name, default, meaning:
- WL, 12, word length of x and result.
- I_BITS, 6, integer bits including sign.
- ORD_W, 4, order width; maximum order is 2^ORD_W-1.
REQ-002 The design SHALL have one clock. Reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be one per line as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, request valid.
- in_ready, out, 1, block idle and able to accept.
- x_in, in, WL, signed fixed-point argument, F=WL-I_BITS fraction bits.
- n_in, in, ORD_W, unsigned polynomial order.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- t_out, out, WL, signed T_n(x), same format as x_in; feeds the saturation stage.

Function
REQ-004 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1. x_in and n_in SHALL be registered at that edge and ignored afterwards.
REQ-005 The FSM SHALL have three states. IDLE drives in_ready=1. ITER iterates. DONE drives out_valid=1. Every other state drives in_ready=0 and out_valid=0.
REQ-006 Transitions SHALL be: IDLE->ITER on accept; ITER->DONE when k>=n; ITER->ITER otherwise; DONE->IDLE when out_ready=1. DONE SHALL hold t_out stable while out_ready=0.
REQ-007 On accept, the block SHALL load t_prev=ONE (1<<F), t_cur=x and k=1.
REQ-008 Each ITER cycle with k<n SHALL compute t_next=2*x*t_cur - t_prev, then shift t_prev<=t_cur, t_cur<=t_next and k<=k+1.
REQ-009 Arithmetic rules:
- 2*x*t_cur SHALL be formed exactly in 2*WL+1 bits.
- It SHALL then be arithmetically shifted right by F (truncation toward minus infinity).
- It SHALL be wrapped to WL bits, and the subtraction of t_prev SHALL wrap to WL bits.
REQ-010 Result selection: n=0 SHALL yield ONE, n=1 SHALL yield x, and n>=2 SHALL yield t_cur at the ITER->DONE transition.
REQ-011 out_valid SHALL rise exactly max(n,1) rising edges after the accepting edge.
REQ-012 In DONE with out_ready=1, the next cycle SHALL be IDLE. Back-to-back requests therefore incur one idle cycle.
REQ-013 t_out SHALL hold its last value outside DONE.
REQ-014 No saturation SHALL be performed. Range reduction belongs to the downstream saturation stage.

Reset
REQ-015 rst=1 SHALL immediately force IDLE with:
- in_ready=1 (the IDLE state drives it).
- out_valid=0.
- t_out=0, t_prev=0, t_cur=0 and k=0.
This applies in any state, including mid-ITER. The interrupted computation SHALL be discarded.
REQ-016 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Configuration
REQ-017 Macro CHEBYSHEV_OVF_EN:
- When defined, an extra output ovf_out (1 bit) SHALL exist. It SHALL be set when any iteration's shifted product or subtraction is not representable in WL signed bits. It SHALL be sticky for the operation, cleared on accept, valid with out_valid, and reset to 0.
- When undefined, the port and its logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-018 Package chebyshev_pkg SHALL hold:
- the FSM state typedef (IDLE, ITER, DONE);
- the fixed-point constants F and ONE, derived from WL and I_BITS;
- the product width constant 2*WL+1.
REQ-019 Sub-module chebyshev_mac SHALL be combinational. It SHALL compute 2*a*b>>F - c with wrap, plus an overflow indication. chebyshev_recurrence SHALL instantiate it once.

Verification (WL=12, I_BITS=6, F=6, ONE=12'h040)
REQ-020 x=12'h020 (0.5), n=2:
- t_out=12'hFE0 (-0.5).
- out_valid 2 edges after accept.
REQ-021 x=12'h020, n=3:
- t_out=12'hFC0 (-1.0).
- out_valid 3 edges after accept.
REQ-022 Order corner cases:
- n=0 with any x: t_out=12'h040 after 1 edge.
- n=1 with x=12'h7C0: t_out=12'h7C0 after 1 edge.
- x=12'h040, n=15: t_out=12'h040.
REQ-023 x=12'h080 (2.0), n=4:
- t_out=12'h840 (wrapped).
- ovf_out=1 with CHEBYSHEV_OVF_EN.
- Any subsequent n=2, x=12'h020 request: ovf_out=0.
REQ-024 Handshake and reset:
- Hold out_ready=0 for 5 cycles in DONE: out_valid and t_out stay stable, and in_ready=0.
- Assert rst mid-ITER (n=10, k=4): next sample shows IDLE, out_valid=0, t_out=0.
